tx_fifo_ctrl: RTL and testbench

TX_FIFO_CTRL -- requirements
Module: tx_fifo_ctrl

---
 rtl/tx_fifo_pkg.sv | 21 ++
 rtl/tx_fifo_rd_pipe.sv | 43 ++++
 rtl/tx_fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_tx_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_fifo_pkg                                                           |
// | Shared sizing constants and pointer/count types for the TX FIFO.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tx_fifo_pkg;

    localparam int unsigned c_WIDTH     = 32;
    localparam int unsigned c_DEPTH     = 128;
    localparam int unsigned c_AWIDTH    = 7;
    localparam int unsigned c_RD_LAT    = 2;
    localparam int unsigned c_AFULL_TH  = 120;
    localparam int unsigned c_AEMPTY_TH = 8;

    // Pointers carry one extra wrap bit; the count must reach DEPTH itself.
    typedef logic [c_AWIDTH:0] ptr_t;
    typedef logic [c_AWIDTH:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_fifo_rd_pipe                                                       |
// | Read-valid delay line matching the RAM read latency, sync clear.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tx_fifo_rd_pipe
    import tx_fifo_pkg::*;
#(
    parameter int unsigned LAT = c_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic [LAT-1:0] r_pipe;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= i_valid;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[LAT-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/tx_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_fifo_ctrl                                                          |
// | FIFO controller driving an external 2-cycle-latency dual-port RAM.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tx_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = c_WIDTH,
    parameter int unsigned DEPTH     = c_DEPTH,
    parameter int unsigned AWIDTH    = c_AWIDTH,
    parameter int unsigned AFULL_TH  = c_AFULL_TH,
    parameter int unsigned AEMPTY_TH = c_AEMPTY_TH
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WE,
    input  logic [WIDTH-1:0]  DATA,
    input  logic              RE,
    output logic [WIDTH-1:0]  Q,
    output logic              DVALID,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [AWIDTH:0]   WRCNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              RAM_WEN,
    output logic [AWIDTH-1:0] RAM_WADDR,
    output logic [WIDTH-1:0]  RAM_WDATA,
    output logic              RAM_REN,
    output logic [AWIDTH-1:0] RAM_RADDR,
    input  logic [WIDTH-1:0]  RAM_RDATA
);

    localparam logic [AWIDTH:0] c_FULL_CNT   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] c_AFULL_CNT  = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] c_AEMPTY_CNT = (AWIDTH+1)'(AEMPTY_TH);

    logic [AWIDTH:0] r_wptr;
    logic [AWIDTH:0] r_rptr;
    logic [AWIDTH:0] r_cnt;
    logic            r_full;
    logic            r_empty;
    logic            r_afull;
    logic            r_aempty;
    logic            r_ovf;
    logic            r_unf;

    logic            w_wacc;
    logic            w_racc;
    logic [AWIDTH:0] w_cnt_nxt;
    logic            w_unused_msb;

    // Flags gate acceptance, so a full FIFO never writes and an empty one never reads.
    assign w_wacc = WE & ~r_full  & ~RESET;
    assign w_racc = RE & ~r_empty & ~RESET;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wacc && !w_racc) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_wacc && w_racc) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wacc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_racc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt    <= w_cnt_nxt;
            // Flags track the count being written on this same edge.
            r_full   <= (w_cnt_nxt == c_FULL_CNT);
            r_empty  <= (w_cnt_nxt == '0);
            r_afull  <= (w_cnt_nxt >= c_AFULL_CNT);
            r_aempty <= (w_cnt_nxt <= c_AEMPTY_CNT);
            r_ovf    <= WE & r_full;
            r_unf    <= RE & r_empty;
        end
    end

    tx_fifo_rd_pipe #(
        .LAT     (c_RD_LAT)
    ) u_rd_pipe (
        .clk     (CLOCK),
        .rst     (RESET),
        .i_valid (w_racc),
        .o_valid (DVALID)
    );

    // Wrap bits are kept as state for observability; occupancy comes from the count.
    assign w_unused_msb = r_wptr[AWIDTH] ^ r_rptr[AWIDTH];

    assign RAM_WEN   = w_wacc;
    assign RAM_WADDR = r_wptr[AWIDTH-1:0];
    assign RAM_WDATA = DATA;
    assign RAM_REN   = w_racc;
    assign RAM_RADDR = r_rptr[AWIDTH-1:0];

    assign Q         = RAM_RDATA;
    assign WRCNT     = r_cnt;
    assign FULL      = r_full;
    assign EMPTY     = r_empty;
    assign AFULL     = r_afull;
    assign AEMPTY    = r_aempty;
    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tx_fifo_ctrl                                                       |
// | Directed table plus scenario sequences against a 2-cycle RAM model.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tx_fifo_ctrl;
    import tx_fifo_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET, WE, RE;
    logic [31:0] DATA, Q, RAM_WDATA, RAM_RDATA;
    logic        DVALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
    logic [7:0]  WRCNT;
    logic        RAM_WEN, RAM_REN;
    logic [6:0]  RAM_WADDR, RAM_RADDR;

    always #5 CLOCK = ~CLOCK;

    tx_fifo_ctrl dut (
        .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE),
        .Q(Q), .DVALID(DVALID), .FULL(FULL), .EMPTY(EMPTY),
        .AFULL(AFULL), .AEMPTY(AEMPTY), .WRCNT(WRCNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_REN(RAM_REN), .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA)
    );

    // Pipelined RAM: address registered, then one output register.
    logic [31:0] mem [128];
    logic [31:0] rd1, rd2;
    always @(posedge CLOCK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
        if (RAM_REN) rd1 <= mem[RAM_RADDR];
        rd2 <= rd1;
    end
    assign RAM_RDATA = rd2;

    int unsigned cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    typedef struct { logic [31:0] data; int unsigned due; } rd_t;
    rd_t         q_rd[$];
    logic [31:0] q_fifo[$];
    int          m_cnt  = 0;
    logic [7:0]  m_wptr = '0;
    logic [7:0]  m_rptr = '0;
    logic        mon_en = 1'b0;

    always @(negedge CLOCK) begin
        if (mon_en) begin
            if (DVALID) begin
                if (q_rd.size() == 0) begin
                    check("dvalid_spurious", DVALID, 1'b0);
                end else begin
                    check("rd_latency", cyc, q_rd[0].due);
                    check("rd_data", Q, q_rd[0].data);
                    void'(q_rd.pop_front());
                end
            end else if (q_rd.size() != 0 && q_rd[0].due <= cyc) begin
                check("dvalid_missing", DVALID, 1'b1);
                void'(q_rd.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_wrcnt"},  WRCNT,  m_cnt);
        check({tag, "_full"},   FULL,   m_cnt == 128);
        check({tag, "_empty"},  EMPTY,  m_cnt == 0);
        check({tag, "_afull"},  AFULL,  m_cnt >= 120);
        check({tag, "_aempty"}, AEMPTY, m_cnt <= 8);
    endtask

    task automatic cycle(input logic we, input logic re, input logic [31:0] d);
        logic wacc, racc, exp_ovf, exp_unf;
        rd_t  e;
        wacc    = we && (m_cnt < 128);
        racc    = re && (m_cnt > 0);
        exp_ovf = we && (m_cnt == 128);
        exp_unf = re && (m_cnt == 0);
        WE = we; RE = re; DATA = d;
        #1;
        check("ram_wen", RAM_WEN, wacc);
        check("ram_ren", RAM_REN, racc);
        if (wacc) begin
            check("ram_waddr", RAM_WADDR, m_wptr[6:0]);
            check("ram_wdata", RAM_WDATA, d);
        end
        if (racc) begin
            check("ram_raddr", RAM_RADDR, m_rptr[6:0]);
            e.data = q_fifo.pop_front();
            e.due  = cyc + 2;
            q_rd.push_back(e);
            m_rptr++;
        end
        if (wacc) begin
            q_fifo.push_back(d);
            m_wptr++;
        end
        if (wacc && !racc) m_cnt++;
        if (racc && !wacc) m_cnt--;
        tick();
        WE = 1'b0; RE = 1'b0;
        check_flags("seq");
        check("seq_overflow",  OVERFLOW,  exp_ovf);
        check("seq_underflow", UNDERFLOW, exp_unf);
    endtask

    task automatic do_reset();
        RESET = 1'b1; WE = 1'b0; RE = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        q_fifo.delete();
        q_rd.delete();
        m_cnt = 0; m_wptr = '0; m_rptr = '0;
    endtask

    task automatic drain(input string tag);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        check({tag, "_drained"}, q_rd.size(), 0);
    endtask

    typedef struct {
        logic        we, re;
        logic [31:0] data;
        logic [7:0]  cnt;
        logic        empty, dv;
        logic [31:0] q;
        logic        unf;
    } vec_t;

    function automatic vec_t mk(int we, int re, int d, int c, int e, int dv, int q, int u);
        vec_t v;
        v.we = 1'(we); v.re = 1'(re); v.data = 32'(d); v.cnt = 8'(c);
        v.empty = 1'(e); v.dv = 1'(dv); v.q = 32'(q); v.unf = 1'(u);
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // Expected values are the state after the vector's clock edge.
        tbl[0]  = mk(1, 0, 'hA,  1, 0, 0, 0,    0);
        tbl[1]  = mk(1, 0, 'hB,  2, 0, 0, 0,    0);
        tbl[2]  = mk(1, 0, 'hC,  3, 0, 0, 0,    0);
        tbl[3]  = mk(0, 1, 0,    2, 0, 0, 0,    0);
        tbl[4]  = mk(0, 1, 0,    1, 0, 1, 'hA,  0);
        tbl[5]  = mk(0, 1, 0,    0, 1, 1, 'hB,  0);
        tbl[6]  = mk(0, 0, 0,    0, 1, 1, 'hC,  0);
        tbl[7]  = mk(0, 0, 0,    0, 1, 0, 0,    0);
        tbl[8]  = mk(1, 1, 'h55, 1, 0, 0, 0,    1);
        tbl[9]  = mk(0, 0, 0,    1, 0, 0, 0,    0);
        tbl[10] = mk(0, 1, 0,    0, 1, 0, 0,    0);
        tbl[11] = mk(0, 0, 0,    0, 1, 1, 'h55, 0);
        tbl[12] = mk(0, 0, 0,    0, 1, 0, 0,    0);
        tbl[13] = mk(0, 1, 0,    0, 1, 0, 0,    1);
        tbl[14] = mk(0, 0, 0,    0, 1, 0, 0,    0);

        // Reset with requests pending: RAM strobes must stay low.
        RESET = 1'b1; WE = 1'b1; RE = 1'b1; DATA = 32'h1234;
        #1;
        check("rst_ram_wen", RAM_WEN, 1'b0);
        check("rst_ram_ren", RAM_REN, 1'b0);
        tick();
        check("rst_wrcnt", WRCNT, 8'd0);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_aempty", AEMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);
        check("rst_afull", AFULL, 1'b0);
        check("rst_dvalid", DVALID, 1'b0);
        check("rst_overflow", OVERFLOW, 1'b0);
        check("rst_underflow", UNDERFLOW, 1'b0);
        RESET = 1'b0; WE = 1'b0; RE = 1'b0;

        for (int i = 0; i < 15; i++) begin
            WE = tbl[i].we; RE = tbl[i].re; DATA = tbl[i].data;
            tick();
            WE = 1'b0; RE = 1'b0;
            check($sformatf("tbl%0d_wrcnt", i), WRCNT, tbl[i].cnt);
            check($sformatf("tbl%0d_empty", i), EMPTY, tbl[i].empty);
            check($sformatf("tbl%0d_dvalid", i), DVALID, tbl[i].dv);
            check($sformatf("tbl%0d_underflow", i), UNDERFLOW, tbl[i].unf);
            check($sformatf("tbl%0d_overflow", i), OVERFLOW, 1'b0);
            if (tbl[i].dv) check($sformatf("tbl%0d_q", i), Q, tbl[i].q);
        end

        mon_en = 1'b1;

        // Fill to full, overflow, then simultaneous push/pop at full.
        do_reset();
        for (int i = 0; i < 128; i++) cycle(1'b1, 1'b0, 32'h100 + i);
        check("fill_full", FULL, 1'b1);
        cycle(1'b1, 1'b0, 32'hDEAD);
        check("ovf_wrcnt", WRCNT, 8'd128);
        cycle(1'b0, 1'b0, 32'h0);
        check("ovf_pulse_end", OVERFLOW, 1'b0);
        cycle(1'b1, 1'b1, 32'hBEEF);
        check("both_full_wrcnt", WRCNT, 8'd127);
        for (int i = 0; i < 127; i++) cycle(1'b0, 1'b1, 32'h0);
        drain("fill");

        // Wrap-around of both pointers.
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 32'h1000 + i);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 1'b0, 32'h2000 + i);
            if (i == 27) check("wptr_wrap", dut.r_wptr, m_wptr);
        end
        check("wrap_wrcnt", WRCNT, 8'd60);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 32'h0);
        drain("wrap");

        // Simultaneous push/pop at empty and at 50 words.
        do_reset();
        cycle(1'b1, 1'b1, 32'h77);
        check("both_empty_underflow", UNDERFLOW, 1'b1);
        for (int i = 0; i < 49; i++) cycle(1'b1, 1'b0, 32'h3000 + i);
        cycle(1'b1, 1'b1, 32'h4000);
        check("both_mid_wrcnt", WRCNT, 8'd50);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 32'h0);
        drain("mid");

        // Reset one cycle after a pop: the in-flight read must vanish.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h5000 + i);
        cycle(1'b0, 1'b1, 32'h0);
        RESET = 1'b1; WE = 1'b1; RE = 1'b1;
        q_fifo.delete(); q_rd.delete();
        m_cnt = 0; m_wptr = '0; m_rptr = '0;
        #1;
        check("midrst_ram_wen", RAM_WEN, 1'b0);
        check("midrst_ram_ren", RAM_REN, 1'b0);
        tick();
        check("midrst_wrcnt", WRCNT, 8'd0);
        check("midrst_empty", EMPTY, 1'b1);
        check("midrst_dvalid", DVALID, 1'b0);
        check("midrst_ram_wen2", RAM_WEN, 1'b0);
        tick();
        check("midrst_dvalid2", DVALID, 1'b0);
        RESET = 1'b0; WE = 1'b0; RE = 1'b0;
        drain("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
